// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port encoding, index type and the mod-5
// port increment used by every round-robin pointer.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  typedef logic [2:0] port_idx_t;

  localparam port_idx_t PORT_N   = 3'd0;
  localparam port_idx_t PORT_S   = 3'd1;
  localparam port_idx_t PORT_E   = 3'd2;
  localparam port_idx_t PORT_W   = 3'd3;
  localparam port_idx_t PORT_L   = 3'd4;
  localparam port_idx_t SEL_IDLE = 3'd7;

  // Five ports do not fill the 3-bit index, so the wrap must be explicit.
  function automatic port_idx_t next_port(input port_idx_t idx);
    return (idx >= PORT_L) ? PORT_N : port_idx_t'(idx + 3'd1);
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Allocator-facing signal bundle: head-flit requests and credits in,
// crossbar selects, pops and send enables out.
interface switch_allocator_if;
  import noc_pkg::*;

  logic [NUM_PORTS-1:0]   req_valid_i;
  logic [3*NUM_PORTS-1:0] req_dest_i;
  logic [NUM_PORTS-1:0]   out_full_i;
  logic [NUM_PORTS-1:0]   in_pop_o;
  logic [NUM_PORTS-1:0]   out_enable_o;
  logic [3*NUM_PORTS-1:0] out_sel_o;
  logic                   err_o;

  modport master (
    output req_valid_i,
    output req_dest_i,
    output out_full_i,
    input  in_pop_o,
    input  out_enable_o,
    input  out_sel_o,
    input  err_o
  );

  modport slave (
    input  req_valid_i,
    input  req_dest_i,
    input  out_full_i,
    output in_pop_o,
    output out_enable_o,
    output out_sel_o,
    output err_o
  );

endinterface

// File: rtl/rr_arbiter5.sv
// Five-way round-robin arbiter for one output port. The grant is combinational;
// only the priority pointer is registered and it moves just past each winner.
module rr_arbiter5
  import noc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 enable,
  output logic                 grant_valid,
  output port_idx_t            grant_idx
);

  port_idx_t ptr_reg;
  port_idx_t ptr_next;
  port_idx_t scan;

  // Walk ptr, ptr+1, ... mod 5 and keep the first requester found.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = SEL_IDLE;
    scan        = ptr_reg;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (enable && !grant_valid && req[scan]) begin
        grant_valid = 1'b1;
        grant_idx   = scan;
      end
      scan = next_port(scan);
    end
  end

  // A disabled (credit-starved) output holds its pointer so the blocked
  // winner keeps priority once credit returns.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_valid) begin
      ptr_next = next_port(grant_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= PORT_N;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Single-stage round-robin switch allocator for the 5-port mesh router:
// legality filtering, one arbiter per existing output, pops and sticky error.
module switch_allocator #(
  parameter logic [4:0] PORT_MASK = 5'b11111,
  parameter logic [2:0] SEL_IDLE  = 3'd7
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave bus
);
  import noc_pkg::*;

  // Zero-extended so a destination code of 5..7 can index it safely.
  localparam logic [7:0] MASK_EXT = {3'b000, PORT_MASK};

  port_idx_t            dest [NUM_PORTS];
  logic [NUM_PORTS-1:0] legal;
  logic [NUM_PORTS-1:0] illegal;
  logic [NUM_PORTS-1:0] cand [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant_valid;
  port_idx_t            grant_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] pop;
  logic                 err_reg;
  logic                 err_next;

  genvar gi;

  // Requests at absent ports are dropped silently; anything else that fails
  // a check is flagged as an error and never reaches arbitration.
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
      assign dest[gi]    = bus.req_dest_i[3*gi +: 3];
      assign legal[gi]   = bus.req_valid_i[gi] && PORT_MASK[gi]
                           && (dest[gi] <= PORT_L) && MASK_EXT[dest[gi]]
                           && (dest[gi] != port_idx_t'(gi));
      assign illegal[gi] = bus.req_valid_i[gi] && PORT_MASK[gi] && !legal[gi];
    end
  endgenerate

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cand[o][p] = legal[p] && (dest[p] == port_idx_t'(o));
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
      if (PORT_MASK[gi]) begin : g_arb
        rr_arbiter5 u_arb (
          .clk         (clk),
          .rst         (rst),
          .req         (cand[gi]),
          .enable      (!bus.out_full_i[gi]),
          .grant_valid (grant_valid[gi]),
          .grant_idx   (grant_idx[gi])
        );
      end else begin : g_absent
        assign grant_valid[gi] = 1'b0;
        assign grant_idx[gi]   = SEL_IDLE;
      end
      assign bus.out_enable_o[gi]     = grant_valid[gi];
      assign bus.out_sel_o[3*gi +: 3] = grant_valid[gi] ? grant_idx[gi] : SEL_IDLE;
    end
  endgenerate

  // Each input targets a single output, so OR-ing the grants never double-pops.
  always_comb begin
    pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant_valid[o] && (grant_idx[o] == port_idx_t'(p))) begin
          pop[p] = 1'b1;
        end
      end
    end
  end

  assign bus.in_pop_o = pop;

  always_comb begin
    err_next = err_reg | (|illegal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign bus.err_o = err_reg;

endmodule
